reg_bank_arbiter: RTL

- Round-robin arbiter and sequencer that shares a small bank of 8-bit registers among several requesters.
- Each requester issues a single read or write transaction. The arbiter picks one winner, performs the access on the shared bank, and returns a one-cycle acknowledge.
- Sits between client blocks and the register storage, so clients never drive the bank directly.

---
 rtl/reg_bank_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that serialises single read/write transactions from
// N_REQ clients onto a shared bank of DEPTH registers, one per 3 cycles.
module reg_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ-1:0]                 we,
  input  logic [N_REQ*$clog2(DEPTH)-1:0]   addr,
  input  logic [N_REQ*WIDTH-1:0]           wdata,
  output logic [N_REQ-1:0]                 gnt,
  output logic [N_REQ-1:0]                 ack,
  output logic [WIDTH-1:0]                 rdata,
  output logic                             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(N_REQ);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];

  logic [IW-1:0]    sel;
  logic [IW-1:0]    cand;
  logic             found;
  int               cand_idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Winner: first raised request scanning upward from the slot after the last one served.
  always_comb begin
    sel      = ptr_q;
    cand     = '0;
    cand_idx = 0;
    found    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = (int'(ptr_q) + k) % N_REQ;
      cand     = IW'(cand_idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end else begin
        found = found;
      end
    end
  end

  // Transaction sequencer: latch operands, grant, then perform the access and acknowledge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = sel;
          we_d    = we[sel];
          addr_d  = addr[sel*AW +: AW];
          wdata_d = wdata[sel*WIDTH +: WIDTH];
          gnt_d   = onehot(sel);
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        gnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          bank_d[addr_q] = wdata_q;
        end else begin
          rdata_d = bank_q[addr_q];
        end
        ack_d   = onehot(win_q);
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight and clears the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule
